pc_gen: RTL

Parametrised program-counter generator for the IF stage; successor to the fixed-step PC register. Produces the fetch address with a valid/ready handshake to instruction memory and a configurable fetch step. Resolves prioritised interrupt and jump redirects. Buffers a redirect that arrives while the PC stage is stalled, so no flush is lost.

---
 rtl/pc_gen_if.sv | 21 ++
 rtl/pc_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/pc_gen_if.sv
// Fetch request channel between the PC generator and instruction memory.
// The master presents an aligned fetch address qualified by req_valid; the slave answers with req_ready.
interface pc_gen_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  req_valid;
  logic                  req_ready;

  modport master (
    output pc,
    output req_valid,
    input  req_ready
  );

  modport slave (
    input  pc,
    input  req_valid,
    output req_ready
  );
endinterface

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: fetch handshake, prioritised interrupt/jump redirects,
// and a one-entry buffer that holds a redirect arriving while the PC stage is stalled.
module pc_gen #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           FETCH_BYTES = 4,
  parameter int unsigned           STALL_WIDTH = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   flush_jump_i,
  input  logic [ADDR_WIDTH-1:0]  jump_pc_i,
  input  logic                   flush_int_i,
  input  logic [ADDR_WIDTH-1:0]  int_pc_i,
  pc_gen_if.master               bus,
  output logic                   ce_o,
  output logic                   redirect_pending_o,
  output logic                   misalign_o
);

  localparam logic [ADDR_WIDTH-1:0] OfsMask  = ADDR_WIDTH'(FETCH_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] Step     = ADDR_WIDTH'(FETCH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ResetPcA = RESET_PC & ~OfsMask;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_q, misalign_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_int_q, pend_int_d;
  logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  logic                  live_vld;
  logic [ADDR_WIDTH-1:0] live_tgt;
  logic                  eff_vld;
  logic [ADDR_WIDTH-1:0] eff_tgt;
  logic                  unused_stall;

  // Only bit 0 (PC-stage hold) matters here; the rest belongs to later stages.
  assign unused_stall = ^stall_i;

  assign live_vld = flush_int_i | flush_jump_i;
  assign live_tgt = flush_int_i ? int_pc_i : jump_pc_i;

  always_comb begin
    eff_vld = 1'b0;
    eff_tgt = pend_tgt_q;
    // A pending entry wins unless a live interrupt competes with a pending jump.
    if (pend_vld_q && !(flush_int_i && !pend_int_q)) begin
      eff_vld = 1'b1;
      eff_tgt = pend_tgt_q;
    end else if (live_vld) begin
      eff_vld = 1'b1;
      eff_tgt = live_tgt;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_int_d = pend_int_q;
    pend_tgt_d = pend_tgt_q;
    unique case (state_q)
      StIdle: begin
        state_d = StRun;
      end
      StRun: begin
        if (stall_i[0]) begin
          if (flush_int_i) begin
            pend_vld_d = 1'b1;
            pend_int_d = 1'b1;
            pend_tgt_d = int_pc_i;
          end else if (flush_jump_i && !(pend_vld_q && pend_int_q)) begin
            pend_vld_d = 1'b1;
            pend_int_d = 1'b0;
            pend_tgt_d = jump_pc_i;
          end
        end else if (eff_vld) begin
          pc_d       = eff_tgt & ~OfsMask;
          misalign_d = |(eff_tgt & OfsMask);
          pend_vld_d = 1'b0;
          pend_int_d = 1'b0;
        end else if (bus.req_ready) begin
          pc_d = pc_q + Step;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      pc_q       <= ResetPcA;
      misalign_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_int_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      pend_vld_q <= pend_vld_d;
      pend_int_q <= pend_int_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign ce_o               = (state_q == StRun);
  assign bus.req_valid      = ce_o;
  assign bus.pc             = pc_q;
  assign redirect_pending_o = pend_vld_q;
  assign misalign_o         = misalign_q;

endmodule
